// File: rtl/gate_check_pkg.sv
// ---------------------------------------------------------------------------
// gate_check_pkg
// Shared types and constants for the gate sweep checker.
//   state_e  : sweep FSM state (IDLE, DRIVE, SAMPLE, FIN), 2-bit encoding
//   TT_*     : expected-output truth tables for 2-input gates; bit i is the
//              expected gate output when the stimulus vector equals i
// ---------------------------------------------------------------------------
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage : gate_check_pkg

// File: rtl/gate_sweep_checker_settle_cnt.sv
// ---------------------------------------------------------------------------
// sweep_settle_cnt
// Settle counter: counts the cycles a stimulus vector has been held.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   clr_i : force the count back to 0
//   en_i  : advance the count; wraps to 0 after reaching SETTLE-1
//   tc_o  : terminal count, high while the count equals SETTLE-1
// ---------------------------------------------------------------------------
module sweep_settle_cnt #(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = (cnt_q == CW'(SETTLE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : sweep_settle_cnt

// File: rtl/gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker
// Drives every input combination of a small gate in ascending order, holds
// each for SETTLE cycles, samples the gate output for one cycle and compares
// it against EXP_TT. Reports pass/fail, mismatch count and first failing
// vector.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   start        : one-cycle sweep request (ignored unless idle)
//   dut_out_i    : output of the gate under test
//   vec_o        : stimulus; vec_o[N_IN-1] is input a (MSB), vec_o[0] is b
//   busy         : high while a sweep is running
//   done         : one-cycle pulse at sweep end
//   pass         : result of last sweep, valid from done to next start
//   err_cnt      : mismatches in current or last sweep
//   first_fail_o : vector of the first mismatch, 0 if none
// Configuration macro:
//   SWEEP_STOP_ON_FAIL_EN : when defined, the first mismatch ends the sweep
// ---------------------------------------------------------------------------
module gate_sweep_checker
    import gate_check_pkg::*;
#(
    parameter int unsigned          N_IN   = 2,
    parameter logic [2**N_IN-1:0]   EXP_TT = 4'b1000,
    parameter int unsigned          SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dut_out_i,
    output logic [N_IN-1:0]   vec_o,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_cnt,
    output logic [N_IN-1:0]   first_fail_o
);

    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(2**N_IN - 1);

`ifdef SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_e          state_q;
    logic [N_IN-1:0] vec_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [N_IN:0]   err_q;
    logic [N_IN-1:0] ff_q;

    logic            settle_tc;
    logic            mismatch;
    logic [N_IN:0]   err_d;

    sweep_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != DRIVE),
        .en_i  (state_q == DRIVE),
        .tc_o  (settle_tc)
    );

    // Count including the current sample, so FIN can report pass from the
    // final total in the same edge that records the last mismatch.
    always_comb begin
        mismatch = (dut_out_i != EXP_TT[vec_q]);
        err_d    = err_q + (N_IN + 1)'(mismatch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= DRIVE;
                        vec_q   <= '0;
                        err_q   <= '0;
                        ff_q    <= '0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (settle_tc) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_q <= err_d;
                        if (err_q == '0) begin
                            ff_q <= vec_q;
                        end
                    end
                    if ((vec_q == LAST_VEC) || (STOP_ON_FAIL && mismatch)) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (err_d == '0);
                    end else begin
                        vec_q   <= vec_q + N_IN'(1);
                        state_q <= DRIVE;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec_o        = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_cnt      = err_q;
    assign first_fail_o = ff_q;

endmodule : gate_sweep_checker

// File: tb/tb_gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_checker
// Directed bench for gate_sweep_checker with default parameters (2-input AND
// truth table, SETTLE=2). The gate under test is a behavioural model whose
// function is selected per scenario. Expected results depend on whether
// SWEEP_STOP_ON_FAIL_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_gate_sweep_checker;
    import gate_check_pkg::*;

    localparam int GATE_AND = 0;
    localparam int GATE_OR  = 1;
    localparam int GATE_ONE = 2;

`ifdef SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dut_out;
    logic [1:0] vec;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [1:0] first_fail;

    int gate_mode = GATE_AND;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (gate_mode)
            GATE_AND: dut_out = vec[1] & vec[0];
            GATE_OR:  dut_out = vec[1] | vec[0];
            default:  dut_out = 1'b1;
        endcase
    end

    gate_sweep_checker #(
        .N_IN   (2),
        .EXP_TT (TT_AND),
        .SETTLE (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dut_out_i    (dut_out),
        .vec_o        (vec),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_cnt      (err_cnt),
        .first_fail_o (first_fail)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({vec, busy, done, pass, err_cnt, first_fail} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got vec=%0d busy=%b done=%b pass=%b err=%0d ff=%0d, need all 0",
                     vec, busy, done, pass, err_cnt, first_fail);
        end
        rst = 1'b0;
    endtask

    // One sweep: start is raised at the next negedge (cycle 0); cycle n is
    // observed at the n-th negedge after that. Runs until done_cyc.
    task automatic run_sweep(input string name, input int mode, input int done_cyc,
                             input bit exp_pass, input int exp_err, input int exp_ff,
                             input int restart_at);
        int done_seen;
        gate_mode = mode;
        done_seen = 0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= done_cyc; n++) begin
            @(negedge clk);
            start = (n == restart_at) ? 1'b1 : 1'b0;
            if (done) done_seen++;
            if (n == 1) begin
                checks++;
                if (busy !== 1'b1 || pass !== 1'b0 || err_cnt !== 3'd0) begin
                    errors++;
                    $display("FAIL %s_start: got busy=%b pass=%b err=%0d, need busy=1 pass=0 err=0",
                             name, busy, pass, err_cnt);
                end
            end
            if (n < done_cyc) begin
                checks++;
                if (vec !== 2'((n - 1) / 3) || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_cyc%0d: got vec=%0d busy=%b done=%b, need vec=%0d busy=1 done=0",
                             name, n, vec, busy, done, (n - 1) / 3);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_cyc%0d: got done=%b busy=%b, need done=1 busy=0",
                     name, done_cyc, done, busy);
        end
        checks++;
        if (pass !== exp_pass || err_cnt !== 3'(exp_err) || first_fail !== 2'(exp_ff)) begin
            errors++;
            $display("FAIL %s_result: got pass=%b err=%0d ff=%0d, need pass=%b err=%0d ff=%0d",
                     name, pass, err_cnt, first_fail, exp_pass, exp_err, exp_ff);
        end
        checks++;
        if (done_seen != 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d done pulses, need 1", name, done_seen);
        end
    endtask

    task automatic test_pass_and();
        run_sweep("and_ok", GATE_AND, 13, 1'b1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || vec !== 2'd3 || pass !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL and_ok_after: got done=%b vec=%0d pass=%b busy=%b, need done=0 vec=3 pass=1 busy=0",
                     done, vec, pass, busy);
        end
    endtask

    task automatic test_fail_or();
        if (STOP) run_sweep("or_bad", GATE_OR, 7, 1'b0, 1, 1, 0);
        else      run_sweep("or_bad", GATE_OR, 13, 1'b0, 2, 1, 0);
    endtask

    task automatic test_start_ignored();
        run_sweep("restart", GATE_AND, 13, 1'b1, 0, 0, 5);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_no_second: got done=%b busy=%b, need 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        gate_mode = GATE_AND;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);   // cycle 7: vec 2 in DRIVE
        checks++;
        if (vec !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got vec=%0d busy=%b, need vec=2 busy=1", vec, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (vec !== 2'd0 || busy !== 1'b0 || err_cnt !== 3'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_post: got vec=%0d busy=%b err=%0d done=%b, need 0 0 0 0",
                     vec, busy, err_cnt, done);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_idle%0d: got done=%b busy=%b, need 0 0", k, done, busy);
            end
        end
        run_sweep("after_rst", GATE_AND, 13, 1'b1, 0, 0, 0);
    endtask

    task automatic test_tied_one();
        if (STOP) run_sweep("tied1", GATE_ONE, 4, 1'b0, 1, 0, 0);
        else      run_sweep("tied1", GATE_ONE, 13, 1'b0, 3, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_sweep("b2b_first", GATE_AND, 13, 1'b1, 0, 0, 0);
        run_sweep("b2b_second", GATE_AND, 13, 1'b1, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_pass_and();
        test_fail_or();
        test_start_ignored();
        test_reset_mid();
        test_tied_one();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_gate_sweep_checker

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Self-checking stimulus stage for small combinational gate blocks. It sits upstream of the gate under test, driving every input combination in ascending binary order. It also sits downstream, sampling the gate output and comparing it against a parameterised truth table. It reports a pass/fail flag and a mismatch count, so gate assignments can be checked in hardware or simulation without a hand-written vector list.

Parameters:
N_IN, 2, number of gate inputs; 1..4
EXP_TT, 4'b1000, expected output for each input index; bit i is the expected out when vec_o==i; width 2**N_IN; default is 2-input AND
SETTLE, 2, cycles each vector is held before sampling; >=1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset: one clock; reset is synchronous and active-high
start  in  1  one-cycle request to begin a sweep
dut_out_i  in  1  output of gate under test
vec_o  out  N_IN  stimulus to gate inputs; vec_o[N_IN-1] is the MSB input (a), vec_o[0] is the LSB input (b)
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse at sweep end
pass  out  1  result of last sweep; valid from the done cycle until the next accepted start
err_cnt  out  N_IN+1  mismatches in the current or last sweep
first_fail_o  out  N_IN  vec_o value of the first mismatch; 0 if none

Behaviour:
- Reset (rst high at an edge), from any state including mid-sweep:
  - state=IDLE.
  - vec_o=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_o=0.
  - settle counter=0.
- FSM states: IDLE, DRIVE, SAMPLE, FIN.
- IDLE:
  - start=1 -> DRIVE.
  - On that edge: vec_o=0, err_cnt=0, first_fail_o=0, pass=0, settle counter=0, busy=1.
- DRIVE:
  - vec_o held stable; counter increments each cycle.
  - When counter==SETTLE-1 -> SAMPLE.
  - DRIVE lasts exactly SETTLE cycles.
- SAMPLE (one cycle):
  - Compare dut_out_i with EXP_TT[vec_o].
  - On mismatch: err_cnt+1; if this is the first mismatch, first_fail_o=vec_o.
  - If vec_o==2**N_IN-1 -> FIN; else vec_o+1, counter=0 -> DRIVE.
- FIN (one cycle):
  - done=1, busy=0, pass=(err_cnt==0) using the final count including the last sample.
  - -> IDLE.
  - vec_o holds its last value until the next start.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - done is high in cycle 2**N_IN*(SETTLE+1)+1 after the start edge.
  - For defaults that is cycle 13.
- start while busy, or in the FIN cycle, is ignored; no queueing.
- Back-to-back sweeps: start in the cycle after done is accepted normally.
- err_cnt saturates naturally: its maximum is 2**N_IN, which fits in N_IN+1 bits, so it never wraps.
- dut_out_i is sampled only in SAMPLE; X or glitches during DRIVE are ignored.

Optional Feature:
SWEEP_STOP_ON_FAIL_EN
- Defined: the first mismatch in SAMPLE goes directly to FIN.
  - err_cnt=1, pass=0, first_fail_o=failing vector.
  - Remaining vectors are not driven.
- Undefined: the full sweep always runs, and err_cnt counts all mismatches.

Decomposition:
- Shared package gate_check_pkg holds:
  - FSM state enum (IDLE, DRIVE, SAMPLE, FIN), 2-bit encoding.
  - Constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111 for N_IN=2.
- One natural sub-module: sweep_settle_cnt, the settle counter.
  - Inputs: clr, en.
  - Output: tc (terminal count) when the count reaches SETTLE-1.

Test Plan:
1. Defaults, dut_out_i = AND of vec_o bits, start pulse.
   - vec_o steps 0,1,2,3, each held 3 cycles.
   - done pulses at cycle 13; pass=1, err_cnt=0, first_fail_o=0.
2. EXP_TT=TT_AND, DUT is OR.
   - Mismatches at vec 1 and 2.
   - done with pass=0, err_cnt=2, first_fail_o=1.
3. Start pulsed again at cycle 5 of an active sweep.
   - Ignored: a single done at cycle 13, and vec_o sequence unchanged.
4. rst asserted while vec_o=2 in DRIVE.
   - Next cycle: vec_o=0, busy=0, err_cnt=0, no done pulse.
   - A fresh start then completes normally.
5. SWEEP_STOP_ON_FAIL_EN defined, DUT tied to 1, EXP_TT=TT_AND.
   - Fail at vec 0: done at cycle 4 with err_cnt=1, first_fail_o=0, pass=0.
6. Two back-to-back sweeps with correct DUT, the second start given the cycle after done.
   - Both report pass=1, err_cnt=0.
   - pass drops to 0 on the second start edge.
